// File: rtl/mio_bridge_pkg.sv
// Shared constants and FSM state type for the CPU data-bus bridge.
package mio_bridge_pkg;

    localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
    localparam logic [31:0] TIMER_ADDR = 32'hF000_0004;
    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        RAM,
        PER,
        ERR,
        DONE
    } state_t;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational region decode of a CPU byte address; misaligned or unmapped goes to sel_err.
module mio_addr_decode
    import mio_bridge_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic [31:0] addr,
    output logic        sel_ram,
    output logic        sel_gpio,
    output logic        sel_timer,
    output logic        sel_err
);

    logic aligned;
    logic in_ram;

    assign aligned   = (addr[1:0] == 2'b00);
    assign in_ram    = ((addr >> (RAM_AW + 2)) == 32'd0);
    assign sel_ram   = aligned && in_ram;
    assign sel_gpio  = (addr == GPIO_ADDR);
    assign sel_timer = (addr == TIMER_ADDR);
    assign sel_err   = !(sel_ram || sel_gpio || sel_timer);

endmodule

// File: rtl/mio_data_bridge.sv
// Bridges the CPU MEM-stage data bus to data RAM, GPIO and a free-running timer,
// inserting wait states and returning a one-cycle completion pulse.
module mio_data_bridge
    import mio_bridge_pkg::*;
#(
    parameter int RAM_WAIT    = 1,
    parameter int PERIPH_WAIT = 2,
    parameter int RAM_AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       gpio_in,
    output logic [31:0]       gpio_out,
    output logic              bus_err
);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        we_reg;
    logic        timer_sel_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic [31:0] gpio_reg;
    logic [31:0] timer_reg;
    logic        err_reg;

    logic sel_ram, sel_gpio, sel_timer, sel_err;
    logic accept;
    logic last_wait;

    mio_addr_decode #(
        .RAM_AW(RAM_AW)
    ) u_decode (
        .addr     (cpu_addr),
        .sel_ram  (sel_ram),
        .sel_gpio (sel_gpio),
        .sel_timer(sel_timer),
        .sel_err  (sel_err)
    );

    assign accept    = (state_reg == IDLE) && cpu_req;
    assign last_wait = (cnt_reg == 4'd0);

    // RAM is driven straight from the live bus in the accept cycle.
    assign ram_addr  = cpu_addr[RAM_AW+1:2];
    assign ram_wdata = cpu_wdata;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    if (sel_ram) begin
                        state_next = RAM;
                        cnt_next   = 4'(RAM_WAIT);
                        ram_en     = 1'b1;
                        ram_we     = cpu_we;
                    end else if (sel_err) begin
                        state_next = ERR;
                    end else begin
                        state_next = PER;
                        cnt_next   = 4'(PERIPH_WAIT);
                    end
                end
            end
            RAM, PER: begin
                if (last_wait) state_next = DONE;
                else           cnt_next   = cnt_reg - 4'd1;
            end
            ERR:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            timer_sel_reg <= 1'b0;
            wdata_reg     <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg        <= cpu_we;
                timer_sel_reg <= sel_timer;
                wdata_reg     <= cpu_wdata;
            end
        end
    end

    // Data path: the last wait cycle captures read data or commits a peripheral write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= 32'd0;
            gpio_reg  <= 32'd0;
            timer_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            if (state_reg == PER && last_wait && we_reg && timer_sel_reg)
                timer_reg <= wdata_reg;
            else
                timer_reg <= timer_reg + 32'd1;

            if (state_reg == PER && last_wait && we_reg && !timer_sel_reg)
                gpio_reg <= wdata_reg;

            if (state_reg == RAM && last_wait && !we_reg)
                rdata_reg <= ram_rdata;
            else if (state_reg == PER && last_wait && !we_reg)
                rdata_reg <= timer_sel_reg ? timer_reg : {16'd0, gpio_in};
            else if (state_reg == ERR)
                rdata_reg <= ERR_DATA;

            if (state_reg == ERR)
                err_reg <= 1'b1;
        end
    end

    assign cpu_ready = (state_reg == DONE);
    assign cpu_rdata = rdata_reg;
    assign gpio_out  = gpio_reg;
    assign bus_err   = err_reg;

endmodule

// File: tb/tb_mio_data_bridge.sv
// Scoreboard bench for mio_data_bridge: driver queues expected read data, a monitor checks each ready pulse.
module tb_mio_data_bridge;
    import mio_bridge_pkg::*;

    localparam int RAM_WAIT    = 1;
    localparam int PERIPH_WAIT = 2;
    localparam int RAM_AW      = 10;
    // Posedges counted from raising req in IDLE up to the one that shows cpu_ready.
    localparam int LAT_RAM = RAM_WAIT + 2;
    localparam int LAT_PER = PERIPH_WAIT + 2;
    localparam int LAT_ERR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;
    logic [15:0]       gpio_in;
    logic [31:0]       gpio_out;
    logic              bus_err;

    always #5 clk = ~clk;

    mio_data_bridge #(
        .RAM_WAIT   (RAM_WAIT),
        .PERIPH_WAIT(PERIPH_WAIT),
        .RAM_AW     (RAM_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .bus_err  (bus_err)
    );

    // Synchronous data RAM, read-first, output held until the next enable.
    logic [31:0] mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int checks = 0;
    int passes = 0;
    int ready_seen = 0;
    int we_pulses = 0;
    logic [RAM_AW-1:0] we_addr = '0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    always @(posedge clk) begin
        if (ram_we) begin
            we_pulses++;
            we_addr = ram_addr;
        end
    end

    always @(negedge clk) begin
        if (rst && cpu_ready) begin
            ready_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ready: got cpu_ready=1 rdata=0x%08h, expected no pending access", cpu_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("txn %0d: rdata=0x%08h expected=0x%08h", ready_seen, cpu_rdata, mon_exp);
                check("rdata", cpu_rdata, mon_exp);
            end
        end
    end

    task automatic access(input string name, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat);
        int  n;
        bit  got;
        exp_q.push_back(exp_rd);
        @(negedge clk);
        cpu_addr  = a;
        cpu_we    = w;
        cpu_wdata = d;
        cpu_req   = 1'b1;
        n   = 0;
        got = 0;
        while (!got && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (cpu_ready) got = 1;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        cpu_req = 1'b0;
        if (got) begin
            @(posedge clk); #1;
            check({name, "_ready_one_cycle"}, 32'(cpu_ready), 32'd0);
        end
    endtask

    int n_wait;
    bit got_rdy;
    int base_ready;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; gpio_in = 16'hC3A5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_gpio", gpio_out, 32'd0);
        @(negedge clk); rst = 1'b1;

        // 1: RAM write then read
        access("ram_wr", 32'h0000_0010, 1'b1, 32'h1234_5678, 32'h0000_0000, LAT_RAM);
        check("ram_we_pulses", 32'(we_pulses), 32'd1);
        check("ram_we_addr", 32'(we_addr), 32'd4);
        access("ram_rd", 32'h0000_0010, 1'b0, 32'd0, 32'h1234_5678, LAT_RAM);
        check("ram_rd_no_we", 32'(we_pulses), 32'd1);

        // 2: GPIO
        access("gpio_wr", 32'hF000_0000, 1'b1, 32'h0000_00A5, 32'h1234_5678, LAT_PER);
        check("gpio_out", gpio_out, 32'h0000_00A5);
        access("gpio_rd", 32'hF000_0000, 1'b0, 32'd0, 32'h0000_C3A5, LAT_PER);

        // 3: timer load near wrap; reads land 4 and 9 cycles after the load
        access("tmr_wr", 32'hF000_0004, 1'b1, 32'hFFFF_FFFE, 32'h0000_C3A5, LAT_PER);
        access("tmr_rd1", 32'hF000_0004, 1'b0, 32'd0, 32'h0000_0002, LAT_PER);
        access("tmr_rd2", 32'hF000_0004, 1'b0, 32'd0, 32'h0000_0007, LAT_PER);

        // 4: error accesses
        access("err_rd", 32'h8000_0000, 1'b0, 32'd0, ERR_DATA, LAT_ERR);
        check("err_rd_bus_err", 32'(bus_err), 32'd1);
        access("err_wr", 32'h0000_0002, 1'b1, 32'h5555_AAAA, ERR_DATA, LAT_ERR);
        check("err_wr_bus_err", 32'(bus_err), 32'd1);
        check("err_wr_no_ram", 32'(we_pulses), 32'd1);
        check("err_wr_gpio", gpio_out, 32'h0000_00A5);
        access("ram_rd_after_err", 32'h0000_0010, 1'b0, 32'd0, 32'h1234_5678, LAT_RAM);

        // 5: reset in the middle of a RAM wait
        base_ready = ready_seen;
        @(negedge clk);
        cpu_addr = 32'h0000_0010; cpu_we = 1'b0; cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        #1;
        check("abort_ready", 32'(cpu_ready), 32'd0);
        check("abort_ram_en", 32'(ram_en), 32'd0);
        check("abort_gpio", gpio_out, 32'd0);
        check("abort_bus_err", 32'(bus_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_ready", 32'(ready_seen - base_ready), 32'd0);
        access("ram_rd_after_rst", 32'h0000_0010, 1'b0, 32'd0, 32'h1234_5678, LAT_RAM);

        // 6: req held across two accesses, dropped one cycle after the second accept
        base_ready = ready_seen;
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        @(negedge clk);
        cpu_addr = 32'h0000_0010; cpu_we = 1'b0; cpu_req = 1'b1;
        n_wait = 0; got_rdy = 0;
        while (!got_rdy && n_wait < 50) begin
            @(posedge clk); #1;
            n_wait++;
            if (cpu_ready) got_rdy = 1;
        end
        check("hold1_latency", 32'(n_wait), 32'(LAT_RAM));
        @(posedge clk); #1;
        check("hold_idle_gap", 32'(cpu_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); cpu_req = 1'b0;
        n_wait = 0; got_rdy = 0;
        while (!got_rdy && n_wait < 50) begin
            @(posedge clk); #1;
            n_wait++;
            if (cpu_ready) got_rdy = 1;
        end
        check("hold2_latency", 32'(n_wait), 32'(RAM_WAIT + 1));
        repeat (6) @(posedge clk);
        #1;
        check("hold_ready_count", 32'(ready_seen - base_ready), 32'd2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
